// File: rtl/pb_keys_capture.sv
// pb_keys_capture: note push-button front end.
// Per-button 2-flop sync + debounce lanes feed a single-key arbitration FSM
// that drives a one-hot-or-zero keys bus plus press/release strobes.

module pb_deb_lane #(
  parameter int DEB_CYCLES = 16,
  parameter int CW         = $clog2(DEB_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // two-flop synchronizer for the asynchronous button line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // flip deb only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (s2 == deb) begin
      cnt <= '0;
    end else if (cnt == CMAX) begin
      deb <= ~deb;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module pb_keys_capture #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] pb_raw,
  output logic [6:0] keys,
  output logic       key_press,
  output logic       key_release,
  output logic       multi_press
);
  localparam int NUM_KEYS = 7;
  localparam int CW       = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PRESSED, WAIT_RELEASE} state_t;

  state_t              state;
  logic [NUM_KEYS-1:0] deb;
  logic [NUM_KEYS-1:0] locked;

  genvar g;
  generate
    for (g = 0; g < NUM_KEYS; g++) begin : g_lane
      pb_deb_lane #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_lane (
        .clk (clk),
        .rst (rst),
        .raw (pb_raw[g]),
        .deb (deb[g])
      );
    end
  endgenerate

  // single-key arbitration; a key never hands off directly to another key,
  // everything must be released before the next press is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      locked      <= '0;
      keys        <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      multi_press <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        IDLE: begin
          if ($onehot(deb)) begin
            locked    <= deb;
            keys      <= deb;
            key_press <= 1'b1;
            state     <= PRESSED;
          end else if (deb != '0) begin
            multi_press <= 1'b1;
            state       <= WAIT_RELEASE;
          end
        end
        PRESSED: begin
          // extra keys while locked are ignored; only losing the locked key matters
          if ((deb & locked) == '0) begin
            keys        <= '0;
            key_release <= 1'b1;
            if (deb == '0) begin
              state <= IDLE;
            end else begin
              multi_press <= 1'b1;
              state       <= WAIT_RELEASE;
            end
          end
        end
        WAIT_RELEASE: begin
          keys <= '0;
          if (deb == '0) begin
            multi_press <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          keys        <= '0;
          multi_press <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/pb_keys_capture.md
# pb_keys_capture

Front end for the seven note push-buttons (A..G). Synchronizes and debounces the raw button lines, enforces a single-key-at-a-time policy, and drives a clean one-hot-or-zero `keys[6:0]` bus into the note decoder (bit 6 = A ... bit 0 = G). It also produces single-cycle press/release strobes for downstream tone and timing logic.

## Interface
- `DEB_CYCLES`, default 16: consecutive stable synchronized samples required before a button's debounced state flips. Legal range ≥ 1. Counter width is `$clog2(DEB_CYCLES+1)`.
- `clk` in 1: system clock; all state is updated on its rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-high. All state clears immediately while `rst`=1.
- `pb_raw` in 7: raw, asynchronous, active-high button lines. Bit 6 = A ... bit 0 = G.
- `keys` out 7: registered. Holds 7'h00 or exactly one bit set; feeds the note decoder.
- `key_press` out 1: registered, one-cycle pulse in the same cycle `keys` goes from 0 to one-hot.
- `key_release` out 1: registered, one-cycle pulse in the same cycle `keys` goes from one-hot to 0.
- `multi_press` out 1: registered level, high while the block is in the WAIT_RELEASE state.

## Operation
- Synchronizer: two flops per bit, `pb_raw` → `s1` → `s2`.
- Debounce, per bit i, with debounced state `deb[i]` and counter `cnt[i]`:
  - If `s2[i]` equals `deb[i]`, `cnt[i]` ← 0.
  - Otherwise `cnt[i]` increments. When `cnt[i]` = DEB_CYCLES−1 and the mismatch persists, `deb[i]` flips and `cnt[i]` ← 0.
  - Any agreeing sample restarts the count. Counters never wrap.
- Arbitration FSM. The states are IDLE, PRESSED and WAIT_RELEASE; `locked` is a 7-bit register.
  - IDLE, `deb` = 0: stay in IDLE.
  - IDLE, exactly one bit of `deb` set: `locked` ← `deb`, `keys` ← `deb`, pulse `key_press`, go to PRESSED.
  - IDLE, two or more bits of `deb` set: go to WAIT_RELEASE. `keys` stays 0 and no pulse is generated.
  - PRESSED, `deb & locked` ≠ 0: hold `keys` = `locked`. Additional keys pressed here are ignored; they do not change `keys` and do not raise `multi_press`.
  - PRESSED, `deb & locked` = 0: `keys` ← 0, pulse `key_release`. Go to IDLE if `deb` = 0, otherwise go to WAIT_RELEASE.
  - WAIT_RELEASE: `keys` = 0. Go to IDLE when `deb` = 0.
- There is never a direct transition from one key to another. A key still held after the locked key is released never produces a press until all keys are released.
- A release in the same cycle as a press of another key (`deb` changes from {A} to {G}) takes the PRESSED → WAIT_RELEASE path.
- Reset values: `s1`, `s2`, `deb`, `cnt` and `locked` = 0; `keys` = 7'h00; `key_press` = 0; `key_release` = 0; `multi_press` = 0; state = IDLE.

## Timing
- A raw edge that is stable from before rising edge 0 appears in `s2` after edge 1.
- `deb` flips at edge DEB_CYCLES+1.
- `keys`, `key_press` and `key_release` update at edge DEB_CYCLES+2. Press and release latency are both DEB_CYCLES+2 cycles.
- `key_press` and `key_release` are each exactly one cycle wide and are never high in the same cycle.
- `multi_press` asserts in the same cycle the FSM enters WAIT_RELEASE.
- Reset asserted mid-press clears `keys` asynchronously and emits no `key_release`.
- A button held through reset deassertion is re-debounced from `deb` = 0: `key_press` occurs DEB_CYCLES+2 cycles after the first edge with `rst` = 0.

## Test plan
- DEB_CYCLES=4, reset, then `pb_raw` = 7'h10 (C) held: `keys` = 7'h10 and `key_press` = 1 for one cycle, 6 cycles after the first sampling edge. Releasing the button gives `keys` = 0 with a `key_release` pulse 6 cycles later.
- DEB_CYCLES=4, `pb_raw` bit 3 toggled high 3 cycles / low 1 cycle, repeated 10 times, then held high: no change in `keys` during the bouncing. `keys` = 7'h08 with a `key_press` pulse 6 cycles after the final rising edge.
- `pb_raw` = 7'h41 (A and G together): `keys` stays 0, `multi_press` = 1, no pulses. Releasing A alone changes nothing. Releasing G leads to `multi_press` = 0 and return to IDLE with no pulse.
- Press A, then press G while A is held: `keys` stays 7'h40 and `multi_press` stays 0. Releasing A gives `key_release`, `keys` = 0, `multi_press` = 1. Releasing G leads to IDLE with no `key_press` for G.
- Hold E (7'h04) until `keys` = 7'h04, then pulse `rst` for 1 cycle: `keys` = 0 immediately with no `key_release`. With E still held, `key_press` and `keys` = 7'h04 occur DEB_CYCLES+2 cycles after `rst` falls.
